// File: rtl/muldiv_ctrl_pkg.sv
// Shared types, opcodes and decode helpers for the M-extension mul/div sequencer.
package muldiv_ctrl_pkg;
    localparam int unsigned XLEN = 64;

    typedef logic [31:0]       u32;
    typedef logic [XLEN-1:0]   u64;
    typedef logic [2*XLEN-1:0] u128;

    typedef enum logic [3:0] {
        MUL    = 4'd0,  MULH  = 4'd1,  MULHSU = 4'd2,  MULHU = 4'd3,
        DIV    = 4'd4,  DIVU  = 4'd5,  REM    = 4'd6,  REMU  = 4'd7,
        MULW   = 4'd8,  DIVW  = 4'd9,  DIVUW  = 4'd10, REMW  = 4'd11,
        REMUW  = 4'd12
    } muldiv_op_t;

    typedef logic [1:0] muldiv_state_t;
    localparam muldiv_state_t IDLE = 2'd0;
    localparam muldiv_state_t CALC = 2'd1;
    localparam muldiv_state_t DONE = 2'd2;

    function automatic logic is_div(muldiv_op_t op);
        return op inside {DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW};
    endfunction

    function automatic logic is_rem(muldiv_op_t op);
        return op inside {REM, REMU, REMW, REMUW};
    endfunction

    function automatic logic is_w(muldiv_op_t op);
        return op inside {MULW, DIVW, DIVUW, REMW, REMUW};
    endfunction

    // rs1 is treated as signed
    function automatic logic is_signed(muldiv_op_t op);
        return op inside {MULH, MULHSU, DIV, REM, DIVW, REMW};
    endfunction

    function automatic logic is_b_signed(muldiv_op_t op);
        return op inside {MULH, DIV, REM, DIVW, REMW};
    endfunction

    function automatic u64 sext32(u32 v);
        return {{32{v[31]}}, v};
    endfunction
endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned core: shift-add multiply / restoring divide, BITS_PER_CY bits per cycle.
module muldiv_iter
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned BITS_PER_CY = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       abort,
    input  logic       is_div,
    input  logic [6:0] len,
    input  u64         a,
    input  u64         b,
    output logic       done,
    output u64         hi,
    output u64         lo
);
    localparam int unsigned B     = BITS_PER_CY;
    localparam int unsigned SHIFT = $clog2(BITS_PER_CY);

    u64          hi_q, lo_q, a_q, b_q;
    logic [6:0]  cnt_q;
    logic        busy_q, is_div_q, w_q;
    u64          step_hi, step_lo, rem_v, quo_v;
    logic [63+B:0] mul_sum;
    logic [64:0] div_t;

    always_comb begin
        mul_sum = {{B{1'b0}}, hi_q} + ({{B{1'b0}}, a_q} * {{64{1'b0}}, lo_q[B-1:0]});
        rem_v   = hi_q;
        quo_v   = lo_q;
        div_t   = '0;
        for (int unsigned i = 0; i < B; i++) begin
            div_t = {rem_v, quo_v[63]};
            quo_v = {quo_v[62:0], 1'b0};
            if (div_t >= {1'b0, b_q}) begin
                div_t    = div_t - {1'b0, b_q};
                quo_v[0] = 1'b1;
            end
            rem_v = div_t[63:0];
        end
        if (is_div_q) begin
            step_hi = rem_v;
            step_lo = quo_v;
        end else begin
            step_hi = mul_sum[63+B:B];
            step_lo = {mul_sum[B-1:0], lo_q[63:B]};
        end
    end

    // The last step is presented combinationally so done lands exactly N cycles after start.
    assign done = busy_q && (cnt_q == 7'd1);
    assign hi   = (!is_div_q && w_q) ? '0 : step_hi;
    assign lo   = (!is_div_q && w_q) ? {step_hi[31:0], step_lo[63:32]} : step_lo;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q     <= '0;
            lo_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            w_q      <= 1'b0;
        end else if (abort) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= len >> SHIFT;
            is_div_q <= is_div;
            w_q      <= (len == 7'd32);
            a_q      <= a;
            b_q      <= b;
            hi_q     <= '0;
            // 32-bit divides align the dividend to the top so the quotient lands in the low half
            lo_q     <= !is_div ? b : ((len == 7'd32) ? {a[31:0], 32'd0} : a);
        end else if (busy_q) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q - 7'd1;
            if (cnt_q == 7'd1) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// Execute-stage mul/div sequencer: operand prep, special cases, iterative core, response hold.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned BITS_PER_CY = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    input  muldiv_op_t req_op,
    input  u64         req_a,
    input  u64         req_b,
    output logic       req_ready,
    output logic       resp_valid,
    input  logic       resp_ready,
    output u64         resp_data,
    output logic       stall,
    input  logic       flush
);
    muldiv_state_t state_q, state_d;
    muldiv_op_t    op_q, op_d;
    logic          neg_q, neg_d;
    u64            resp_data_q, resp_data_d;

    logic op_w, op_div, op_rem, a_sgn, b_sgn, a_neg, b_neg;
    logic div_zero, div_ovf, special, core_start, core_done;
    u64   a_ext, b_ext, a_mag, b_mag, special_res;
    u64   core_hi, core_lo, div_val, div_fix, calc_res;
    u128  prod, prod_fix;

    assign op_w   = is_w(req_op);
    assign op_div = is_div(req_op);
    assign op_rem = is_rem(req_op);
    assign a_sgn  = is_signed(req_op);
    assign b_sgn  = is_b_signed(req_op);

    assign a_ext = op_w ? (a_sgn ? sext32(req_a[31:0]) : {32'd0, req_a[31:0]}) : req_a;
    assign b_ext = op_w ? (b_sgn ? sext32(req_b[31:0]) : {32'd0, req_b[31:0]}) : req_b;
    assign a_neg = a_sgn && a_ext[63];
    assign b_neg = b_sgn && b_ext[63];
    assign a_mag = a_neg ? (64'd0 - a_ext) : a_ext;
    assign b_mag = b_neg ? (64'd0 - b_ext) : b_ext;

    assign div_zero = (b_ext == '0);
    assign div_ovf  = a_sgn && op_div && (b_ext == '1) &&
                      (a_ext == (op_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    assign special  = op_div ? (div_zero || div_ovf) : ((a_ext == '0) || (b_ext == '0));

    always_comb begin
        special_res = '0;
        if (op_div && div_zero) begin
            special_res = op_rem ? (op_w ? sext32(req_a[31:0]) : req_a) : '1;
        end else if (op_div) begin
            special_res = op_rem ? '0 : a_ext;
        end
    end

    muldiv_iter #(
        .BITS_PER_CY(BITS_PER_CY)
    ) u_iter (
        .clk    (clk),
        .resetn (resetn),
        .start  (core_start),
        .abort  (flush),
        .is_div (op_div),
        .len    (op_w ? 7'd32 : 7'd64),
        .a      (a_mag),
        .b      (b_mag),
        .done   (core_done),
        .hi     (core_hi),
        .lo     (core_lo)
    );

    always_comb begin
        prod     = {core_hi, core_lo};
        prod_fix = neg_q ? (~prod + 128'd1) : prod;
        div_val  = is_rem(op_q) ? core_hi : core_lo;
        div_fix  = neg_q ? (64'd0 - div_val) : div_val;
        case (op_q)
            MUL:                      calc_res = prod_fix[63:0];
            MULH, MULHSU, MULHU:      calc_res = prod_fix[127:64];
            MULW:                     calc_res = sext32(prod_fix[31:0]);
            DIVW, DIVUW, REMW, REMUW: calc_res = sext32(div_fix[31:0]);
            default:                  calc_res = div_fix;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        neg_d       = neg_q;
        resp_data_d = resp_data_q;
        core_start  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    op_d  = req_op;
                    neg_d = op_rem ? a_neg : (a_neg ^ b_neg);
                    if (special) begin
                        resp_data_d = special_res;
                        state_d     = DONE;
                    end else begin
                        core_start = 1'b1;
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (core_done) begin
                    resp_data_d = calc_res;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (flush || resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            op_q        <= MUL;
            neg_q       <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_data  = resp_data_q;
    assign stall      = req_valid && !(resp_valid && resp_ready);
endmodule
